// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter. Each grant is followed by one idle cycle, and
// a grant is revoked when the requester has held it for HOLD_MAX cycles.
module rr_arbiter_4 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_GRANT = 1'b1;
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    logic       state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    logic [3:0] gnt_q, gnt_d;
    logic       timeout_q, timeout_d;

    logic       pick_vld;
    logic [1:0] pick_idx;
    logic [1:0] cand;
    logic       expire;
    logic       rel;

    // First set request found when scanning upward from the priority pointer.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        cand     = ptr_q;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign expire = (cnt_q == HOLD_LIM);
    assign rel    = done || !req[gnt_idx_q] || !en || expire;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;
        if (state_q == S_IDLE) begin
            if (en && pick_vld) begin
                state_d   = S_GRANT;
                gnt_idx_d = pick_idx;
                gnt_d     = 4'b0001 << pick_idx;
                cnt_d     = 8'd1;
            end
        end else begin
            if (rel) begin
                state_d   = S_IDLE;
                ptr_d     = gnt_idx_q + 2'd1;
                gnt_d     = '0;
                // Timeout flags only a pure expiry, not a coincident release.
                timeout_d = expire && !done && req[gnt_idx_q] && en;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = state_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: rotation, hold expiry, enable, reset and
// HOLD_MAX=1 behaviour, with hand-computed expected grants.
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic [3:0] gnt, gnt1;
    logic [1:0] gnt_idx, gnt_idx1;
    logic       gnt_vld, gnt_vld1;
    logic       timeout, timeout1;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rr_arbiter_4 #(.HOLD_MAX(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
    );

    rr_arbiter_4 #(.HOLD_MAX(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
        .gnt(gnt1), .gnt_idx(gnt_idx1), .gnt_vld(gnt_vld1), .timeout(timeout1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; req = '0; done = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        en = 1'b0; req = '0; done = 1'b0;
        rst_n = 1'b0;
        #3;
        tests_run++;
        if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        tests_run++;
        if (gnt_idx !== 2'b00) begin fails++; $display("FAIL reset_idx: got %b expected 00", gnt_idx); end
        tests_run++;
        if (gnt_vld !== 1'b0) begin fails++; $display("FAIL reset_vld: got %b expected 0", gnt_vld); end
        tests_run++;
        if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        do_reset();
    endtask

    task automatic test_rotation();
        logic [3:0] exp_seq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                    4'b0000, 4'b1000, 4'b0000, 4'b0001};
        do_reset();
        en = 1'b1; req = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            tick();
            tests_run++;
            if (gnt !== exp_seq[k]) begin
                fails++; $display("FAIL rotation[%0d]: got %b expected %b", k, gnt, exp_seq[k]);
            end
            done = (exp_seq[k] != 4'b0000);
        end
        done = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        en = 1'b1; req = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            tick();
            tests_run++;
            if (gnt !== 4'b0100 || timeout !== 1'b0) begin
                fails++; $display("FAIL hold[%0d]: got gnt=%b to=%b expected gnt=0100 to=0", k, gnt, timeout);
            end
        end
        tick();
        tests_run++;
        if (gnt !== 4'b0000 || timeout !== 1'b1) begin
            fails++; $display("FAIL expiry: got gnt=%b to=%b expected gnt=0000 to=1", gnt, timeout);
        end
        tick();
        tests_run++;
        if (gnt !== 4'b0100 || timeout !== 1'b0) begin
            fails++; $display("FAIL regrant: got gnt=%b to=%b expected gnt=0100 to=0", gnt, timeout);
        end
        req = 4'b0000;
        tick();
        tests_run++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            fails++; $display("FAIL req_drop: got gnt=%b to=%b expected gnt=0000 to=0", gnt, timeout);
        end
    endtask

    task automatic test_ptr_wrap();
        do_reset();
        en = 1'b1; req = 4'b1000;
        tick();
        tests_run++;
        if (gnt !== 4'b1000) begin fails++; $display("FAIL wrap_g3: got %b expected 1000", gnt); end
        req = 4'b1001; done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tests_run++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
            fails++; $display("FAIL wrap_g0: got gnt=%b idx=%0d expected 0001 idx=0", gnt, gnt_idx);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tests_run++;
        if (gnt !== 4'b0000 || gnt_idx !== 2'd0) begin
            fails++; $display("FAIL wrap_gap: got gnt=%b idx=%0d expected 0000 idx=0", gnt, gnt_idx);
        end
        tick();
        tests_run++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
            fails++; $display("FAIL wrap_g3b: got gnt=%b idx=%0d expected 1000 idx=3", gnt, gnt_idx);
        end
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b0; req = 4'b0010; done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (gnt !== 4'b0000) begin fails++; $display("FAIL en_off[%0d]: got %b expected 0000", k, gnt); end
        end
        done = 1'b0; en = 1'b1;
        tick();
        tests_run++;
        if (gnt !== 4'b0010) begin fails++; $display("FAIL en_on: got %b expected 0010", gnt); end
        en = 1'b0;
        tick();
        tests_run++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
            fails++; $display("FAIL en_drop: got gnt=%b vld=%b to=%b expected 0000 0 0", gnt, gnt_vld, timeout);
        end
    endtask

    task automatic test_other_req();
        do_reset();
        en = 1'b1; req = 4'b0001;
        tick();
        req = 4'b1111;
        tick();
        tests_run++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
            fails++; $display("FAIL other_req: got gnt=%b idx=%0d expected 0001 idx=0", gnt, gnt_idx);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        en = 1'b1; req = 4'b0100;
        tick();
        tests_run++;
        if (gnt !== 4'b0100) begin fails++; $display("FAIL mid_pre: got %b expected 0100", gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
            fails++; $display("FAIL mid_async: got gnt=%b vld=%b expected 0000 0", gnt, gnt_vld);
        end
        @(negedge clk);
        rst_n = 1'b1; req = 4'b0110;
        tick();
        tests_run++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
            fails++; $display("FAIL mid_after: got gnt=%b idx=%0d expected 0010 idx=1", gnt, gnt_idx);
        end
    endtask

    task automatic test_done_expiry();
        do_reset();
        en = 1'b1; req = 4'b0100;
        for (int k = 0; k < 8; k++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tests_run++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            fails++; $display("FAIL done_expiry: got gnt=%b to=%b expected 0000 0", gnt, timeout);
        end
    endtask

    task automatic test_hold1();
        do_reset();
        en = 1'b1; req = 4'b0001;
        tick();
        tests_run++;
        if (gnt1 !== 4'b0001 || timeout1 !== 1'b0) begin
            fails++; $display("FAIL h1_grant: got gnt=%b to=%b expected 0001 0", gnt1, timeout1);
        end
        tick();
        tests_run++;
        if (gnt1 !== 4'b0000 || timeout1 !== 1'b1) begin
            fails++; $display("FAIL h1_expire: got gnt=%b to=%b expected 0000 1", gnt1, timeout1);
        end
        tick();
        tests_run++;
        if (gnt1 !== 4'b0001 || timeout1 !== 1'b0) begin
            fails++; $display("FAIL h1_regrant: got gnt=%b to=%b expected 0001 0", gnt1, timeout1);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tests_run++;
        if (gnt1 !== 4'b0000 || timeout1 !== 1'b0) begin
            fails++; $display("FAIL h1_done: got gnt=%b to=%b expected 0000 0", gnt1, timeout1);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_timeout();
        test_ptr_wrap();
        test_enable();
        test_other_req();
        test_reset_mid_grant();
        test_done_expiry();
        test_hold1();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
